// File: rtl/cache_write_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller: one request at a time,
// one word per line, dirty lines written back to a synchronous RAM on eviction.
module cache_write_ctrl #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned IDX_W   = 2,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        hit_cnt,
  output logic [7:0]        miss_cnt
);

  localparam int unsigned LINES = 2 ** IDX_W;
  localparam int unsigned TAG_W = ADDR_W - IDX_W;
  localparam int unsigned CNT_W = $clog2(MEM_LAT + 2);

  typedef enum logic [2:0] {StIdle, StLookup, StWb, StFill, StResp} state_e;

  state_e              state_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                hit_q;
  logic [CNT_W-1:0]    fill_cnt_q;
  logic [LINES-1:0]    valid_q;
  logic [LINES-1:0]    dirty_q;
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [DATA_W-1:0]   data_q [LINES];

  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    req_tag;
  logic                lookup_hit;

  assign idx        = addr_q[IDX_W-1:0];
  assign req_tag    = addr_q[ADDR_W-1:IDX_W];
  assign lookup_hit = valid_q[idx] && (tag_q[idx] == req_tag);
  assign req_ready  = (state_q == StIdle);

  // Gating with reset keeps an in-flight write-back from reaching the RAM.
  always_comb begin
    mem_we    = (state_q == StWb) && !reset;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == StWb) begin
      mem_addr  = {tag_q[idx], idx};
      mem_wdata = data_q[idx];
    end else if (state_q == StFill) begin
      mem_addr  = addr_q;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      hit_q      <= 1'b0;
      fill_cnt_q <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
      rsp_valid  <= 1'b0;
      rsp_hit    <= 1'b0;
      rsp_rdata  <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            state_q <= StLookup;
          end
        end
        StLookup: begin
          hit_q      <= lookup_hit;
          fill_cnt_q <= '0;
          if (lookup_hit) begin
            if (we_q) begin
              data_q[idx]  <= wdata_q;
              dirty_q[idx] <= 1'b1;
            end
            if (hit_cnt != 8'hFF) hit_cnt <= hit_cnt + 8'd1;
            state_q <= StResp;
          end else begin
            if (miss_cnt != 8'hFF) miss_cnt <= miss_cnt + 8'd1;
            state_q <= (valid_q[idx] && dirty_q[idx]) ? StWb : StFill;
          end
        end
        StWb: state_q <= StFill;
        StFill: begin
          // RAM data is valid on the last of the MEM_LAT+1 address cycles.
          if (fill_cnt_q == CNT_W'(MEM_LAT)) begin
            valid_q[idx] <= 1'b1;
            tag_q[idx]   <= req_tag;
            data_q[idx]  <= we_q ? wdata_q : mem_rdata;
            dirty_q[idx] <= we_q;
            state_q      <= StResp;
          end else begin
            fill_cnt_q <= fill_cnt_q + 1'b1;
          end
        end
        StResp: begin
          rsp_valid <= 1'b1;
          rsp_hit   <= hit_q;
          rsp_rdata <= data_q[idx];
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_write_ctrl.sv
// Self-checking bench for cache_write_ctrl: directed scenarios plus random traffic,
// checked against a line-level cache/RAM model.
module tb_cache_write_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       req_valid, req_we;
  logic [4:0] req_addr;
  logic [7:0] req_wdata;
  logic       req_ready, rsp_valid, rsp_hit;
  logic [7:0] rsp_rdata;
  logic [4:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata, mem_rdata;
  logic [7:0] hit_cnt, miss_cnt;

  always #5 CLOCK_50 = ~CLOCK_50;

  cache_write_ctrl #(.ADDR_W(5), .DATA_W(8), .IDX_W(2), .MEM_LAT(1)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .req_valid(req_valid),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_hit  (rsp_hit),
    .rsp_rdata(rsp_rdata),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  // Synchronous RAM, one cycle read latency; preload restores mem[a] = a ^ 8'h30.
  logic       preload;
  logic [7:0] ram [32];
  always @(posedge CLOCK_50) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) ram[i] <= 8'(i) ^ 8'h30;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  // Write-back monitor.
  int         wb_cnt;
  logic [4:0] wb_addr;
  logic [7:0] wb_data;
  always @(negedge CLOCK_50) begin
    if (mem_we) begin
      wb_cnt  = wb_cnt + 1;
      wb_addr = mem_addr;
      wb_data = mem_wdata;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: cache lines and RAM image.
  logic       m_valid [4];
  logic       m_dirty [4];
  logic [2:0] m_tag   [4];
  logic [7:0] m_data  [4];
  logic [7:0] ref_mem [32];
  int         m_hits, m_misses;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
      m_data[i]  = '0;
    end
    for (int i = 0; i < 32; i++) ref_mem[i] = 8'(i) ^ 8'h30;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic model_op(input logic we, input logic [4:0] addr, input logic [7:0] wdata,
                          output logic hit, output logic [7:0] rdata, output int lat,
                          output int wbs, output logic [4:0] wba, output logic [7:0] wbd);
    int         i;
    logic [2:0] t;
    i   = int'(addr[1:0]);
    t   = addr[4:2];
    wbs = 0;
    wba = '0;
    wbd = '0;
    hit = m_valid[i] && (m_tag[i] == t);
    if (hit) begin
      m_hits = (m_hits < 255) ? m_hits + 1 : 255;
      if (we) begin
        m_data[i]  = wdata;
        m_dirty[i] = 1'b1;
      end
      lat = 2;
    end else begin
      m_misses = (m_misses < 255) ? m_misses + 1 : 255;
      lat = 4;
      if (m_valid[i] && m_dirty[i]) begin
        wbs = 1;
        wba = {m_tag[i], addr[1:0]};
        wbd = m_data[i];
        ref_mem[wba] = wbd;
        lat = 5;
      end
      m_valid[i] = 1'b1;
      m_tag[i]   = t;
      m_data[i]  = we ? wdata : ref_mem[addr];
      m_dirty[i] = we;
    end
    rdata = m_data[i];
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    reset   = 1'b1;
    preload = 1'b1;
    req_valid = 1'b0;
    @(posedge CLOCK_50);
    #1;
    reset   = 1'b0;
    preload = 1'b0;
    model_reset();
  endtask

  // Issue one request, wait for its response and check it against the model.
  task automatic do_req(input logic we, input logic [4:0] addr, input logic [7:0] wdata,
                        input bit junk, output logic o_hit, output logic [7:0] o_rdata);
    logic       e_hit;
    logic [7:0] e_rdata;
    int         e_lat, e_wbs, lat, n;
    logic [4:0] e_wba;
    logic [7:0] e_wbd;
    model_op(we, addr, wdata, e_hit, e_rdata, e_lat, e_wbs, e_wba, e_wbd);
    @(negedge CLOCK_50);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    wb_cnt    = 0;
    @(posedge CLOCK_50);
    #1;
    lat = 0;
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      if (junk && !req_ready) begin
        req_valid = 1'b1;
        req_we    = 1'($urandom);
        req_addr  = 5'($urandom);
        req_wdata = 8'($urandom);
      end else begin
        req_valid = 1'b0;
      end
      @(posedge CLOCK_50);
      #1;
      if (rsp_valid) lat = k;
      else if (junk) chk("ready_low_busy", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    o_hit   = rsp_hit;
    o_rdata = rsp_rdata;
    chk("rsp_latency", 32'(lat), 32'(e_lat));
    chk("rsp_hit", {31'd0, rsp_hit}, {31'd0, e_hit});
    chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e_rdata});
    chk("hit_cnt", {24'd0, hit_cnt}, 32'(m_hits));
    chk("miss_cnt", {24'd0, miss_cnt}, 32'(m_misses));
    chk("mem_addr_idle", {27'd0, mem_addr}, 32'd0);
    chk("wb_count", 32'(wb_cnt), 32'(e_wbs));
    if (e_wbs == 1) begin
      chk("wb_addr", {27'd0, wb_addr}, {27'd0, e_wba});
      chk("wb_data", {24'd0, wb_data}, {24'd0, e_wbd});
    end
  endtask

  logic       h;
  logic [7:0] d;
  int         bad;

  initial begin
    reset = 1'b1; preload = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    wb_cnt = 0;
    model_reset();
    do_reset();

    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_hit", {31'd0, rsp_hit}, 32'd0);
    chk("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {27'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("rst_counters", {16'd0, hit_cnt, miss_cnt}, 32'd0);

    // Cold read miss, then hit on the same address.
    do_req(1'b0, 5'h05, 8'h00, 1'b0, h, d);
    chk("t1_rdata", {24'd0, d}, 32'h35);
    do_req(1'b0, 5'h05, 8'h00, 1'b0, h, d);
    chk("t1_hit", {31'd0, h}, 32'd1);

    // Write hit makes the line dirty; conflicting read forces a write-back.
    do_req(1'b1, 5'h05, 8'hA7, 1'b0, h, d);
    do_req(1'b0, 5'h15, 8'h00, 1'b0, h, d);
    chk("t2_rdata", {24'd0, d}, 32'h25);
    do_req(1'b0, 5'h05, 8'h00, 1'b0, h, d);
    chk("t2_reread", {23'd0, h, d}, 32'h0A7);

    // Write-allocate on a clean miss, then evict it.
    do_req(1'b1, 5'h0A, 8'h5F, 1'b0, h, d);
    chk("t3_wmiss", {23'd0, h, d}, 32'h05F);
    do_req(1'b0, 5'h0A, 8'h00, 1'b0, h, d);
    chk("t3_rhit", {23'd0, h, d}, 32'h15F);
    do_req(1'b0, 5'h1A, 8'h00, 1'b0, h, d);

    // Requests held while busy must be ignored.
    for (int i = 0; i < 20; i++)
      do_req(1'b1, {3'($urandom_range(0, 2)), 2'($urandom)}, 8'($urandom), 1'b1, h, d);

    // Reset during a write-back aborts it.
    do_reset();
    do_req(1'b0, 5'h05, 8'h00, 1'b0, h, d);
    do_req(1'b1, 5'h05, 8'hA7, 1'b0, h, d);
    @(negedge CLOCK_50);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 5'h15; req_wdata = 8'h00;
    @(posedge CLOCK_50);
    #1 req_valid = 1'b0;
    @(posedge CLOCK_50);
    #1 chk("t5_in_wb", {31'd0, mem_we}, 32'd1);
    @(negedge CLOCK_50);
    reset = 1'b1;
    @(posedge CLOCK_50);
    #1 reset = 1'b0;
    chk("t5_ready", {31'd0, req_ready}, 32'd1);
    chk("t5_mem_we", {31'd0, mem_we}, 32'd0);
    chk("t5_counters", {16'd0, hit_cnt, miss_cnt}, 32'd0);
    model_reset();
    do_req(1'b0, 5'h05, 8'h00, 1'b0, h, d);
    chk("t5_ram_kept", {23'd0, h, d}, 32'h035);

    // Random traffic over a few conflicting tags.
    do_reset();
    for (int i = 0; i < 150; i++)
      do_req(1'($urandom), {3'($urandom_range(0, 2)), 2'($urandom)}, 8'($urandom),
             1'($urandom), h, d);

    // Counter saturation.
    do_reset();
    for (int i = 0; i < 301; i++) do_req(1'b0, 5'h03, 8'h00, 1'b0, h, d);
    chk("t6_hit_sat", {24'd0, hit_cnt}, 32'd255);
    for (int i = 0; i < 300; i++) do_req(1'b0, (i % 2 == 0) ? 5'h07 : 5'h03, 8'h00, 1'b0, h, d);
    chk("t6_miss_sat", {24'd0, miss_cnt}, 32'd255);

    // RAM image must match the model after all write-backs.
    do_req(1'b1, 5'h02, 8'hC3, 1'b0, h, d);
    do_req(1'b0, 5'h12, 8'h00, 1'b0, h, d);
    @(negedge CLOCK_50);
    bad = 0;
    for (int i = 0; i < 32; i++) if (ram[i] !== ref_mem[i]) bad++;
    chk("ram_image", 32'(bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
